fft_peak_reader: RTL and testbench
==================================

# fft_peak_reader

Consumes the natural-order output stream of the in-place FFT core, one `POINTS`-bin frame at a time. For each bin it forms the magnitude estimate |re|+|im| and tracks the largest bin and its index. At frame end it presents the peak with a valid/acknowledge handshake to the downstream acquisition/tracking logic. It sits directly on the FFT core's DATAO_* / DATAO_VALID / OUTP_READY outputs.

## Interface
- POINTS, 256: bins per frame; power of two, 16..4096.
- DATA_W, 32: width of DATAO_RE/DATAO_IM, two's complement.
- IDX_W, 8: bin index width, equal to log2(POINTS).
- SKIP_DC, 1: when 1, bin 0 is excluded from the peak search.

Ports:
- CLK  in  1  single clock, rising edge; shared with the FFT core.
- RST  in  1  synchronous, active-high reset.
- CLKEN  in  1  FFT clock enable; a beat occurs only when DATAO_VALID and CLKEN are both high.
- DATAO_RE  in  DATA_W  real part of the current bin.
- DATAO_IM  in  DATA_W  imaginary part of the current bin.
- DATAO_VALID  in  1  FFT output sample valid.
- OUTP_READY  in  1  FFT output phase active; a rising edge marks the start of a frame.
- PEAK_VALID  out  1  result available; held until acknowledged.
- PEAK_ACK  in  1  result consumed; sampled only while PEAK_VALID is high.
- PEAK_BIN  out  IDX_W  index of the maximum bin.
- PEAK_MAG  out  DATA_W+1  |re|+|im| of the maximum bin, unsigned.
- FRAME_CNT  out  16  count of completed frames; wraps at 65535 to 0.
- DROP_ERR  out  1  sticky: a result was overwritten while unacknowledged.
- SYNC_ERR  out  1  sticky: a partial frame was aborted by an OUTP_READY rising edge.

## Operation
- Magnitude: abs() of each operand is taken as DATA_W-bit unsigned, so -2^(DATA_W-1) maps to 2^(DATA_W-1) without saturation. The sum is DATA_W+1 bits, with no overflow possible.
- Pipeline:
  - S1 registers abs(re), abs(im), bin index and a last flag.
  - S2 registers the sum and compares it.
  - The pipeline advances every CLK; the S1 valid bit equals the beat.
- Bin counter: 0..POINTS-1, incremented on each beat. The beat carrying count POINTS-1 is flagged last, and the counter wraps to 0.
- Peak tracking: running max and index are loaded unconditionally on bin 0 (bin 1 when SKIP_DC=1). On later bins they update only if the new value is strictly greater, so the lowest index wins a tie. Bin 0 with SKIP_DC=1 is still counted but never compared.
- State machine:
  - IDLE: no beats yet in the current frame. The first beat goes to ACC.
  - ACC: accumulating. The S2 last beat goes to DONE.
  - DONE: one cycle. It loads the PEAK_* registers, sets PEAK_VALID, increments FRAME_CNT, then returns to IDLE.
- Handshake:
  - PEAK_VALID & PEAK_ACK clears PEAK_VALID on the next edge.
  - If DONE and an ACK occur in the same cycle, the new result wins and PEAK_VALID stays 1.
  - If DONE occurs while PEAK_VALID=1 with no ACK, the registers are overwritten and DROP_ERR is set.
- Resync: OUTP_READY is registered, and its rising edge is detected.
  - If the edge arrives with a nonzero bin count, the partial frame is discarded, SYNC_ERR is set and the count returns to 0.
  - A beat in the same cycle as the edge is bin 0.
- Sticky flags clear only on RST.

## Timing
- Reset values:
  - PEAK_VALID=0, PEAK_BIN=0, PEAK_MAG=0, FRAME_CNT=0, DROP_ERR=0, SYNC_ERR=0.
  - State is IDLE, the bin counter is 0 and the pipeline valids are 0.
- Latency: PEAK_VALID rises on the 3rd CLK edge after the edge that samples the final beat. PEAK_BIN, PEAK_MAG and FRAME_CNT update on that same edge.
- Beats may be non-consecutive (CLKEN or DATAO_VALID gaps). Gaps do not alter the results.
- Back-to-back frames with zero gap are supported; the next frame's bin 0 may arrive the cycle after the last bin.
- RST mid-frame discards all partial state. The first beat after reset is bin 0.
- PEAK_ACK while PEAK_VALID=0 is ignored.

## Test plan
- Single-impulse frame: bin 37 = (1000, -500), all others 0 → PEAK_BIN=37, PEAK_MAG=1500, FRAME_CNT=1, PEAK_VALID rising 3 edges after the last beat.
- Tie and DC skip: bins 0, 10 and 200 all have magnitude 4096, SKIP_DC=1 → PEAK_BIN=10. With SKIP_DC=0 → PEAK_BIN=0.
- Extreme values: bin 255 = (-2^31, -2^31) → PEAK_MAG=2^32 (0x1_0000_0000), PEAK_BIN=255.
- Gapped and back-to-back stream: random CLKEN/DATAO_VALID gaps in frame A, frame B immediately after, ACK each result → both peaks correct, FRAME_CNT=2, DROP_ERR=0.
- Overwrite: hold PEAK_ACK=0 across two frames → second result shown, DROP_ERR=1. ACK in the same cycle as DONE → PEAK_VALID stays 1.
- Resync and reset: OUTP_READY rising edge after 100 beats → SYNC_ERR=1, the next 256 beats form a correct frame. RST mid-frame → all outputs 0, the next full frame is correct.

Source files
------------

// File: rtl/fft_peak_reader.sv
// Peak-bin finder for the FFT core's natural-order output stream.
// Tracks max |re|+|im| per frame and hands the result off with valid/ack.
module fft_peak_reader #(
   parameter int POINTS  = 256,
   parameter int DATA_W  = 32,
   parameter int IDX_W   = 8,
   parameter bit SKIP_DC = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLKEN,
   input  logic [DATA_W-1:0] DATAO_RE,
   input  logic [DATA_W-1:0] DATAO_IM,
   input  logic              DATAO_VALID,
   input  logic              OUTP_READY,
   output logic              PEAK_VALID,
   input  logic              PEAK_ACK,
   output logic [IDX_W-1:0]  PEAK_BIN,
   output logic [DATA_W:0]   PEAK_MAG,
   output logic [15:0]       FRAME_CNT,
   output logic              DROP_ERR,
   output logic              SYNC_ERR
);

   localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(POINTS - 1);
   localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(SKIP_DC ? 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   logic              beat;
   logic              rise;
   logic              sync_hit;
   logic              rdy_q;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_re;
   logic [DATA_W-1:0] s1_im;
   logic [IDX_W-1:0]  s1_idx;
   logic              s1_last;

   logic              s2_valid;
   logic [DATA_W:0]   s2_sum;
   logic [IDX_W-1:0]  s2_idx;
   logic              s2_last;

   logic [DATA_W:0]   max_mag;
   logic [IDX_W-1:0]  max_idx;
   logic [DATA_W:0]   sum;
   logic              take;
   logic              better;

   // Unsigned result keeps the most negative input exact (no saturation).
   function automatic logic [DATA_W-1:0] mag_abs(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? -v : v;
   endfunction

   assign beat     = DATAO_VALID & CLKEN;
   assign rise     = OUTP_READY & ~rdy_q;
   assign sync_hit = rise & (cnt != '0);
   assign idx      = rise ? '0 : cnt;
   assign sum      = {1'b0, s1_re} + {1'b0, s1_im};
   assign take     = s2_valid & (s2_idx == FIRST_BIN);
   assign better   = s2_valid & ~(SKIP_DC && (s2_idx == '0))
                   & (s2_sum > max_mag);

   always_ff @(posedge CLK) begin
      if (RST) begin
         rdy_q    <= 1'b0;
         cnt      <= '0;
         s1_valid <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_idx   <= '0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_idx   <= '0;
         s2_last  <= 1'b0;
         max_mag  <= '0;
         max_idx  <= '0;
      end else begin
         rdy_q    <= OUTP_READY;
         cnt      <= beat ? idx + IDX_W'(1) : idx;
         s1_valid <= beat;
         s1_re    <= mag_abs(DATAO_RE);
         s1_im    <= mag_abs(DATAO_IM);
         s1_idx   <= idx;
         s1_last  <= beat & (idx == LAST_BIN);
         s2_valid <= s1_valid;
         s2_sum   <= sum;
         s2_idx   <= s1_idx;
         s2_last  <= s1_valid & s1_last;
         if (take || better) begin
            max_mag <= s2_sum;
            max_idx <= s2_idx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         PEAK_VALID <= 1'b0;
         PEAK_BIN   <= '0;
         PEAK_MAG   <= '0;
         FRAME_CNT  <= '0;
         DROP_ERR   <= 1'b0;
         SYNC_ERR   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (s2_last)
                  state <= DONE;
               else if (beat)
                  state <= ACC;
            end
            ACC: begin
               // A completed frame in S2 outranks a resync of the next one.
               if (s2_last)
                  state <= DONE;
               else if (sync_hit && !beat)
                  state <= IDLE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (state == DONE) begin
            PEAK_VALID <= 1'b1;
            PEAK_BIN   <= max_idx;
            PEAK_MAG   <= max_mag;
            FRAME_CNT  <= FRAME_CNT + 16'd1;
            if (PEAK_VALID && !PEAK_ACK)
               DROP_ERR <= 1'b1;
         end else if (PEAK_VALID && PEAK_ACK) begin
            PEAK_VALID <= 1'b0;
         end

         if (sync_hit)
            SYNC_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Bench for fft_peak_reader: vector table of sparse frames plus
// hand-written overwrite, resync and reset sequences, checked via scoreboard.
module tb_fft_peak_reader;

   localparam int POINTS = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst = 1'b1;
   logic        clken = 1'b0;
   logic        valid = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] re = '0;
   logic [31:0] im = '0;
   logic        ack;
   logic        ack_auto = 1'b1;
   logic        ack_force = 1'b0;

   logic        pv1, drop1, sync1;
   logic [7:0]  bin1;
   logic [32:0] mag1;
   logic [15:0] cnt1;
   logic        pv0, drop0, sync0;
   logic [7:0]  bin0;
   logic [32:0] mag0;
   logic [15:0] cnt0;

   assign ack = ack_force | (ack_auto & pv1);

   fft_peak_reader #(
      .POINTS(256), .DATA_W(32), .IDX_W(8), .SKIP_DC(1'b1)
   ) dut1 (
      .CLK(clk), .RST(rst), .CLKEN(clken),
      .DATAO_RE(re), .DATAO_IM(im), .DATAO_VALID(valid),
      .OUTP_READY(rdy), .PEAK_VALID(pv1), .PEAK_ACK(ack),
      .PEAK_BIN(bin1), .PEAK_MAG(mag1), .FRAME_CNT(cnt1),
      .DROP_ERR(drop1), .SYNC_ERR(sync1)
   );

   fft_peak_reader #(
      .POINTS(256), .DATA_W(32), .IDX_W(8), .SKIP_DC(1'b0)
   ) dut0 (
      .CLK(clk), .RST(rst), .CLKEN(clken),
      .DATAO_RE(re), .DATAO_IM(im), .DATAO_VALID(valid),
      .OUTP_READY(rdy), .PEAK_VALID(pv0), .PEAK_ACK(ack),
      .PEAK_BIN(bin0), .PEAK_MAG(mag0), .FRAME_CNT(cnt0),
      .DROP_ERR(drop0), .SYNC_ERR(sync0)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  bin;
      longint      mag;
      logic [15:0] cnt;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];
   logic [15:0] exp_cnt = '0;

   task automatic push_exp(input logic [7:0] b1, input longint m1,
                           input logic [7:0] b0, input longint m0,
                           input int last);
      exp_t e;
      exp_cnt = exp_cnt + 16'd1;
      e.cnt = exp_cnt;
      e.due = last + 4;
      e.bin = b1; e.mag = m1;
      q1.push_back(e);
      e.bin = b0; e.mag = m0;
      q0.push_back(e);
   endtask

   task automatic check_exp(input string nm, input exp_t e,
                            input logic [7:0] b, input logic [32:0] m,
                            input logic [15:0] c, input logic v);
      check({nm, " bin"}, b, e.bin);
      check({nm, " mag"}, m, e.mag);
      check({nm, " frame_cnt"}, c, e.cnt);
      check({nm, " latency"}, cyc, e.due);
      check({nm, " valid"}, v, 1);
   endtask

   logic [15:0] prev1 = '0;
   logic [15:0] prev0 = '0;

   // Every FRAME_CNT step is one DONE: pop and compare the expected result.
   always @(negedge clk) begin
      if (!rst && cnt1 != prev1) begin
         check("dut1 pending", q1.size(), 1);
         if (q1.size() > 0)
            check_exp("dut1", q1.pop_front(), bin1, mag1, cnt1, pv1);
      end
      if (!rst && cnt0 != prev0) begin
         check("dut0 pending", q0.size(), 1);
         if (q0.size() > 0)
            check_exp("dut0", q0.pop_front(), bin0, mag0, cnt0, pv0);
      end
      prev1 <= cnt1;
      prev0 <= cnt0;
   end

   logic [31:0] fr_re [POINTS];
   logic [31:0] fr_im [POINTS];

   task automatic clear_frame();
      for (int i = 0; i < POINTS; i++) begin
         fr_re[i] = '0;
         fr_im[i] = '0;
      end
   endtask

   task automatic set_bin(input int b, input longint r, input longint i);
      if (b >= 0) begin
         fr_re[b] = r[31:0];
         fr_im[b] = i[31:0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      clken = 1'b0;
      repeat (n) step();
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) step();
   endtask

   // Up to 'gap' filler cycles before each beat, with VALID or CLKEN low.
   task automatic drive_beats(input int n, input int gap, output int last);
      int ng;
      int sel;
      last = cyc;
      for (int b = 0; b < n; b++) begin
         ng = (gap > 0) ? int'($urandom_range(gap)) : 0;
         repeat (ng) begin
            sel = int'($urandom_range(2));
            valid = (sel == 1);
            clken = (sel == 0);
            re = $urandom;
            im = $urandom;
            step();
         end
         valid = 1'b1;
         clken = 1'b1;
         rdy = 1'b1;
         re = fr_re[b];
         im = fr_im[b];
         last = cyc;
         step();
      end
      valid = 1'b0;
      clken = 1'b0;
   endtask

   typedef struct packed {
      int     ba; longint ra; longint ia;
      int     bb; longint rb; longint ib;
      int     bc; longint rc; longint ic;
      int     gap;
      int     eb1; longint em1;
      int     eb0; longint em0;
   } vec_t;

   localparam longint MINV = 64'shFFFF_FFFF_8000_0000;
   vec_t vt [7];

   initial begin
      int last;
      vt[0] = '{37, 1000, -500, -1, 0, 0, -1, 0, 0, 0,
                37, 1500, 37, 1500};
      vt[1] = '{0, 4096, 0, 10, 0, -4096, 200, 2048, -2048, 0,
                10, 4096, 0, 4096};
      vt[2] = '{255, MINV, MINV, -1, 0, 0, -1, 0, 0, 0,
                255, 64'sh1_0000_0000, 255, 64'sh1_0000_0000};
      vt[3] = '{5, -7, 3, 100, 3, 3, -1, 0, 0, 2,
                5, 10, 5, 10};
      vt[4] = '{0, 5000, 0, 128, 100, -200, 129, -300, 0, 0,
                128, 300, 0, 5000};
      vt[5] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 0,
                1, 0, 0, 0};
      vt[6] = '{1, -2147483647, 2147483647, 2, MINV, 0, -1, 0, 0, 2,
                1, 64'sd4294967294, 1, 64'sd4294967294};

      repeat (3) step();
      check("reset valid", pv1, 0);
      check("reset bin", bin1, 0);
      check("reset mag", mag1, 0);
      check("reset frame_cnt", cnt1, 0);
      check("reset drop", drop1, 0);
      check("reset sync", sync1, 0);
      check("reset dut0 valid", pv0, 0);
      rst = 1'b0;

      // Table frames, all back-to-back, auto-acknowledged.
      for (int v = 0; v < 7; v++) begin
         clear_frame();
         set_bin(vt[v].ba, vt[v].ra, vt[v].ia);
         set_bin(vt[v].bb, vt[v].rb, vt[v].ib);
         set_bin(vt[v].bc, vt[v].rc, vt[v].ic);
         drive_beats(POINTS, vt[v].gap, last);
         push_exp(8'(vt[v].eb1), vt[v].em1, 8'(vt[v].eb0), vt[v].em0, last);
      end
      wait_cyc(last + 8);
      check("table drained", q1.size(), 0);
      check("table frame_cnt", cnt1, 7);
      check("table drop", drop1, 0);
      check("table sync", sync1, 0);
      check("table valid cleared", pv1, 0);

      // Hold results unacknowledged; ack exactly in the DONE cycle once.
      ack_auto = 1'b0;
      clear_frame();
      set_bin(7, 3, 4);
      drive_beats(POINTS, 0, last);
      push_exp(7, 7, 7, 7, last);
      wait_cyc(last + 6);
      check("held valid", pv1, 1);
      check("held drop", drop1, 0);

      clear_frame();
      set_bin(200, -9, 0);
      drive_beats(POINTS, 0, last);
      push_exp(200, 9, 200, 9, last);
      wait_cyc(last + 3);
      ack_force = 1'b1;
      wait_cyc(last + 4);
      ack_force = 1'b0;
      wait_cyc(last + 6);
      check("ack on done valid", pv1, 1);
      check("ack on done drop", drop1, 0);

      clear_frame();
      set_bin(99, 0, 123);
      drive_beats(POINTS, 0, last);
      push_exp(99, 123, 99, 123, last);
      wait_cyc(last + 6);
      check("overwrite valid", pv1, 1);
      check("overwrite drop", drop1, 1);
      check("overwrite drop dut0", drop0, 1);

      ack_force = 1'b1;
      step();
      ack_force = 1'b0;
      check("ack clears valid", pv1, 0);
      ack_force = 1'b1;
      step();
      ack_force = 1'b0;
      step();
      check("idle ack ignored", pv1, 0);
      check("idle ack keeps bin", bin1, 99);
      ack_auto = 1'b1;

      // Partial frame, then a fresh OUTP_READY edge with the next bin 0.
      rdy = 1'b0;
      idle(2);
      clear_frame();
      set_bin(50, 99999, 0);
      drive_beats(100, 0, last);
      rdy = 1'b0;
      idle(2);
      check("pre-resync sync", sync1, 0);
      clear_frame();
      set_bin(20, 12, -30);
      drive_beats(POINTS, 0, last);
      push_exp(20, 42, 20, 42, last);
      wait_cyc(last + 8);
      check("resync sync", sync1, 1);
      check("resync sync dut0", sync0, 1);
      check("resync drained", q1.size(), 0);

      // Reset in the middle of a frame.
      clear_frame();
      set_bin(30, 5555, 0);
      drive_beats(50, 1, last);
      rst = 1'b1;
      idle(2);
      check("midrst valid", pv1, 0);
      check("midrst bin", bin1, 0);
      check("midrst mag", mag1, 0);
      check("midrst frame_cnt", cnt1, 0);
      check("midrst drop", drop1, 0);
      check("midrst sync", sync1, 0);
      rst = 1'b0;
      exp_cnt = '0;
      clear_frame();
      set_bin(0, 9999, 9999);
      set_bin(250, 0, -77);
      drive_beats(POINTS, 0, last);
      push_exp(250, 77, 0, 19998, last);
      wait_cyc(last + 8);
      check("post-reset frame_cnt", cnt1, 1);
      check("post-reset sync", sync1, 0);
      check("final drained dut1", q1.size(), 0);
      check("final drained dut0", q0.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
